// File: rtl/addsub_pkg.sv
// addsub_pkg: op encodings and carry-in selection shared by the adder/subtractor pipeline.
package addsub_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    function automatic logic eff_carry(input logic [1:0] op, input logic cin);
        return (op == OP_ADC || op == OP_SBC) ? cin : (op == OP_SUB);
    endfunction

    function automatic logic is_sub(input logic [1:0] op);
        return op == OP_SUB || op == OP_SBC;
    endfunction
endpackage

// File: rtl/addsub_pipe_rca.sv
// rca_slice: combinational ripple-carry adder for one SLICE-bit segment.
module rca_slice
    import addsub_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [SLICE:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign s        = a ^ b ^ c[SLICE-1:0];
    assign cout     = c[SLICE];
    assign c_msb_in = c[SLICE-1];
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor, one SLICE-bit carry segment per stage,
// valid/ready on both sides with a single global stall.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);
    localparam int STAGES = WIDTH / SLICE;

    logic                              adv;
    logic [STAGES-1:0][WIDTH-1:0]      a_q, b_q, r_q, a_d, b_d, r_d;
    logic [STAGES-1:0]                 c_q, z_q, v_q, z_d, v_d, c_in;
    logic [STAGES-1:0][SLICE-1:0]      s;
    logic [STAGES-1:0]                 co, cm;
    logic                              ov_q;
    logic                              unused;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand/carry routing into each stage; kept apart from the sum merge to avoid a comb loop through the slices.
    always_comb begin
        a_d[0]  = A;
        b_d[0]  = is_sub(op) ? ~B : B;
        c_in[0] = eff_carry(op, Cin);
        v_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            c_in[k] = c_q[k-1];
            v_d[k]  = v_q[k-1];
        end
    end

    always_comb begin
        r_d[0] = WIDTH'(s[0]);
        z_d[0] = ~|s[0];
        for (int k = 1; k < STAGES; k++) begin
            r_d[k] = r_q[k-1] | (WIDTH'(s[k]) << (k * SLICE));
            z_d[k] = z_q[k-1] & ~|s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        rca_slice #(.SLICE(SLICE)) u_rca (
            .a        (a_d[k][k*SLICE +: SLICE]),
            .b        (b_d[k][k*SLICE +: SLICE]),
            .cin      (c_in[k]),
            .s        (s[k]),
            .cout     (co[k]),
            .c_msb_in (cm[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            r_q  <= '0;
            c_q  <= '0;
            z_q  <= '0;
            v_q  <= '0;
            ov_q <= 1'b0;
        end else if (adv) begin
            a_q  <= a_d;
            b_q  <= b_d;
            r_q  <= r_d;
            c_q  <= co;
            z_q  <= z_d;
            v_q  <= v_d;
            ov_q <= co[STAGES-1] ^ cm[STAGES-1];
        end
    end

    // Already-consumed operand bits and non-top carry-into-MSB taps have no reader.
    assign unused = ^{a_q, b_q, cm};

    assign out_valid = v_q[STAGES-1];
    assign Result    = r_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign Zero      = z_q[STAGES-1];
    assign Overflow  = ov_q;
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor, successor to the fixed 4-bit combinational adder/subtractor. The carry chain is split into SLICE-bit segments, with one segment resolved per pipeline stage. This gives one result per cycle at a clock rate independent of WIDTH. The block sits between operand sources and consumers in the datapath and uses a valid/ready handshake on both sides. It adds carry-in/borrow-in chaining plus Overflow and Zero flags.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits resolved per pipeline stage; STAGES = WIDTH/SLICE, which is also the latency.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- op  in  2  operation: 00 A+B, 01 A−B, 10 A+B+Cin, 11 A−B−(~Cin)
- Cin  in  1  carry-in for op 10, or active-low borrow-in for op 11; ignored for ops 00/01
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- Result  out  WIDTH  sum/difference modulo 2^WIDTH
- Cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- Overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
- Zero  out  1  Result == 0

## Operation
- Effective addend is B for ops 00/10 and ~B for ops 01/11.
- Effective carry-in is 0 for op 00, 1 for op 01, and Cin for ops 10/11.
- Result = A + addend + carry, truncated to WIDTH bits.
- Stage k (k = 0..STAGES−1) adds bits [k·SLICE +: SLICE] using the carry registered from stage k−1.
  - Unconsumed upper operand bits are carried forward in stage registers.
  - Completed lower result bits are carried forward in stage registers.
- Overflow and Zero are computed in the final stage. Zero is the AND of the per-slice zero bits, accumulated through the pipeline.
- Flow control uses a global stall. Let adv = !out_valid || out_ready.
  - When adv = 1, every stage register and its valid bit shifts forward one stage.
  - When adv = 0, every stage register holds.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Bubbles (invalid stages) travel through the pipeline. They are not squeezed out.
- Output fields are the last-stage registers. They stay stable while out_valid && !out_ready.

## Timing
- Latency: a beat accepted at edge n produces out_valid = 1 after edge n+STAGES, provided no stall occurs. Each stalled cycle adds one.
- Throughput: one beat per cycle when out_ready is held high.
- Reset (rst_n = 0 at an edge): all valid bits clear, and Result, Cout, Overflow and Zero become 0.
  - in_ready reads 1 during and after reset.
- Reset mid-operation drops every in-flight beat. No partial result is presented.
- Simultaneous accept and deliver: when out_valid && out_ready && in_valid, the new beat enters stage 0 in the same cycle the head beat leaves.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- WIDTH == SLICE gives a single-stage registered adder with latency 1.

## Structure
- Package addsub_pkg holds the op encodings OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11.
- One sub-module: rca_slice #(SLICE), a combinational ripple-carry adder.
  - Ports: a, b, cin, s, cout, c_msb_in. c_msb_in is used only by the top slice for Overflow.
  - It is instantiated once per stage.
- Top level holds the operand-inversion mux, the per-stage skew registers, the valid bits and the global stall.

## Test plan
Default parameters: WIDTH=16, SLICE=4, latency 4.
- Reset: hold rst_n=0 for 2 cycles with in_valid=1.
  - Required: out_valid=0, Result=0, in_ready=1.
  - After release, the first beat appears exactly 4 cycles after acceptance.
- Add with full carry ripple: A=16'hFFFF, B=16'h0001, op=00.
  - Required: Result=0000, Cout=1, Zero=1, Overflow=0.
- Subtract with signed overflow: A=16'h8000, B=16'h0001, op=01.
  - Required: Result=7FFF, Cout=1, Overflow=1.
  - Also: A=0003, B=0005, op=01 gives Result=FFFE, Cout=0, Overflow=0.
- Chained 32-bit add: op=00 on low halves 0000_FFFF + 0000_0001, giving Cout=1.
  - Then op=10 on the high halves with Cin=1.
  - Required: high Result=0001.
- Backpressure: stream 8 beats, A=i, B=i, op=00, with out_ready low on cycles 3–6.
  - Required: results 0,2,4,…,14 appear in order with none lost or duplicated.
  - in_ready is low exactly while out_valid && !out_ready.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight.
  - Required: none of them emerges.
  - The next accepted beat returns after 4 cycles with the correct value.
